fifo_sync_ram_fwft: RTL and testbench

Parametrised single-clock first-word-fall-through FIFO built on a generic inferred 1W1R synchronous-read RAM. It succeeds the fixed 256x32 sky130 FIFO, which has only full/empty flags, and adds:
- configurable width and depth;
- an exported fill level;
- programmable almost-full and almost-empty flags;
- a synchronous flush;
- sticky overflow and underflow flags.

It sits between stream producers/consumers inside one clock domain, e.g. bus-to-peripheral data buffering.

---
 rtl/fifo_sync_ram_fwft_if.sv | 29 ++
 rtl/fifo_sync_ram_fwft.sv | 125 ++++++++++++
 tb/tb_fifo_sync_ram_fwft.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_ram_fwft_if.sv
// Handshake bundle for fifo_sync_ram_fwft: write side, read side,
// flush control and status. master = FIFO user, slave = FIFO itself.
interface fifo_sync_ram_fwft_if #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 8
);
    logic              flush;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ena;
    logic              wr_full;
    logic              wr_afull;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_ena;
    logic              rd_empty;
    logic              rd_aempty;
    logic [AWIDTH:0]   level;
    logic              wr_ovf;
    logic              rd_udf;

    modport master (
        output flush, wr_data, wr_ena, rd_ena,
        input  wr_full, wr_afull, rd_data, rd_empty, rd_aempty, level, wr_ovf, rd_udf
    );

    modport slave (
        input  flush, wr_data, wr_ena, rd_ena,
        output wr_full, wr_afull, rd_data, rd_empty, rd_aempty, level, wr_ovf, rd_udf
    );
endinterface

// File: rtl/fifo_sync_ram_fwft.sv
// Single-clock first-word-fall-through FIFO on an inferred 1W1R RAM with
// registered read. The RAM read register doubles as the output stage, so
// rd_data comes straight from the RAM read port.
module fifo_sync_ram_fwft #(
    parameter int WIDTH      = 32,
    parameter int AWIDTH     = 8,
    parameter int AFULL_LVL  = (2 ** AWIDTH) - 4,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_sync_ram_fwft_if.slave       bus
);
    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_LVL  = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_THR  = (AWIDTH + 1)'(AFULL_LVL);
    localparam logic [AWIDTH:0] AEMPTY_THR = (AWIDTH + 1)'(AEMPTY_LVL);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  rd_data_reg;

    logic [AWIDTH-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AWIDTH-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AWIDTH:0]   level_reg, level_next;
    logic              out_valid_reg, out_valid_next;
    logic              ovf_reg, ovf_next;
    logic              udf_reg, udf_next;

    logic              full_w;
    logic              push_w;
    logic              pop_w;
    logic              fetch_w;
    logic [AWIDTH:0]   ram_cnt_w;

    // Status flags depend only on the registered level.
    assign full_w = (level_reg == DEPTH_LVL);

    // Accepted operations; flush and rst suppress everything.
    assign push_w = bus.wr_ena & ~full_w & ~bus.flush & ~rst;
    assign pop_w  = bus.rd_ena & out_valid_reg & ~bus.flush & ~rst;

    // Words held in RAM that have not yet been moved to the output stage.
    // A word pushed on this edge is not counted yet, so the read address
    // never equals the address being written on the same edge.
    assign ram_cnt_w = level_reg - {{AWIDTH{1'b0}}, out_valid_reg};
    assign fetch_w   = (ram_cnt_w != '0) & (~out_valid_reg | pop_w) & ~bus.flush & ~rst;

    // Next-state computation for pointers, level, output stage and sticky flags.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        level_next     = level_reg;
        out_valid_next = out_valid_reg;
        ovf_next       = ovf_reg;
        udf_next       = udf_reg;

        if (push_w) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (fetch_w) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case ({push_w, pop_w})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase

        if (fetch_w) begin
            out_valid_next = 1'b1;
        end else if (pop_w) begin
            out_valid_next = 1'b0;
        end

        if (bus.wr_ena & full_w) begin
            ovf_next = 1'b1;
        end
        if (bus.rd_ena & ~out_valid_reg) begin
            udf_next = 1'b1;
        end
    end

    // Control state register; rst and flush both return to the empty state.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            out_valid_reg <= 1'b0;
            ovf_reg       <= 1'b0;
            udf_reg       <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            level_reg     <= level_next;
            out_valid_reg <= out_valid_next;
            ovf_reg       <= ovf_next;
            udf_reg       <= udf_next;
        end
    end

    // RAM write port.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    // RAM registered read port; its register is the FWFT output stage.
    always_ff @(posedge clk) begin
        if (fetch_w) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign bus.rd_data   = rd_data_reg;
    assign bus.rd_empty  = ~out_valid_reg;
    assign bus.level     = level_reg;
    assign bus.wr_full   = full_w;
    assign bus.wr_afull  = (level_reg >= AFULL_THR);
    assign bus.rd_aempty = (level_reg <= AEMPTY_THR);
    assign bus.wr_ovf    = ovf_reg;
    assign bus.rd_udf    = udf_reg;
endmodule

// File: tb/tb_fifo_sync_ram_fwft.sv
// Directed bench for fifo_sync_ram_fwft (WIDTH=32, DEPTH=16, AFULL=12,
// AEMPTY=2). A queue model predicts every output after every edge; literal
// checks in the stimulus pin the model to hand-derived values.
module tb_fifo_sync_ram_fwft;
    localparam int WIDTH  = 32;
    localparam int AWIDTH = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 12;
    localparam int AEMPTY = 2;

    logic clk;
    logic rst;

    fifo_sync_ram_fwft_if #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) bus ();

    fifo_sync_ram_fwft #(
        .WIDTH(WIDTH), .AWIDTH(AWIDTH), .AFULL_LVL(AFULL), .AEMPTY_LVL(AEMPTY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each stored word remembers the edge it was pushed on. A word is
    // presented once an edge has passed after its push edge and it is at
    // the head of the queue.
    logic [31:0] q_data[$];
    int          q_edge[$];
    int          edge_no = 0;
    bit          m_ovf = 0;
    bit          m_udf = 0;

    always @(posedge clk) begin
        bit vis;
        bit full;
        bit do_push;
        bit do_pop;
        edge_no++;
        if (rst || bus.flush) begin
            q_data.delete();
            q_edge.delete();
            m_ovf = 0;
            m_udf = 0;
        end else begin
            vis     = (q_data.size() > 0) && (q_edge[0] < edge_no - 1);
            full    = (q_data.size() == DEPTH);
            do_pop  = bus.rd_ena && vis;
            do_push = bus.wr_ena && !full;
            if (bus.rd_ena && !vis) m_udf = 1;
            if (bus.wr_ena && full)  m_ovf = 1;
            if (do_pop) begin
                void'(q_data.pop_front());
                void'(q_edge.pop_front());
            end
            if (do_push) begin
                q_data.push_back(bus.wr_data);
                q_edge.push_back(edge_no);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        bit exp_empty;
        int lvl;
        #2;
        lvl       = q_data.size();
        exp_empty = !((lvl > 0) && (q_edge[0] < edge_no));
        check("m_level",  32'(bus.level),     32'(lvl));
        check("m_empty",  32'(bus.rd_empty),  32'(exp_empty));
        check("m_full",   32'(bus.wr_full),   32'(lvl == DEPTH));
        check("m_afull",  32'(bus.wr_afull),  32'(lvl >= AFULL));
        check("m_aempty", 32'(bus.rd_aempty), 32'(lvl <= AEMPTY));
        check("m_ovf",    32'(bus.wr_ovf),    32'(m_ovf));
        check("m_udf",    32'(bus.rd_udf),    32'(m_udf));
        if (!exp_empty) check("m_rd_data", bus.rd_data, q_data[0]);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we, input logic [31:0] wd, input logic re, input logic fl);
        @(negedge clk);
        bus.wr_ena  = we;
        bus.wr_data = wd;
        bus.rd_ena  = re;
        bus.flush   = fl;
        @(posedge clk);
        #3;
    endtask

    initial begin
        int sent;
        int recv;
        int first_c;
        int last_c;
        int max_lvl;

        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.wr_ena  = 1'b0;
        bus.rd_ena  = 1'b0;
        bus.wr_data = '0;

        // 1. reset values
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_level",  32'(bus.level),     0);
        check("rst_empty",  32'(bus.rd_empty),  1);
        check("rst_aempty", 32'(bus.rd_aempty), 1);
        check("rst_full",   32'(bus.wr_full),   0);
        check("rst_afull",  32'(bus.wr_afull),  0);
        check("rst_flags",  32'({bus.wr_ovf, bus.rd_udf}), 0);
        $display("reset done");

        // 2. first-word latency
        step(1, 32'hA5A5_0001, 0, 0);
        check("fw_level_e0", 32'(bus.level),    1);
        check("fw_empty_e0", 32'(bus.rd_empty), 1);
        step(0, 0, 0, 0);
        check("fw_empty_e1", 32'(bus.rd_empty), 0);
        check("fw_data_e1",  bus.rd_data, 32'hA5A5_0001);
        step(0, 0, 1, 0);
        check("fw_pop_empty", 32'(bus.rd_empty), 1);
        $display("first word: data=0x%08h", 32'hA5A5_0001);

        // 3. fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 32'(i), 0, 0);
            if (i == 10) check("fill_afull_11", 32'(bus.wr_afull), 0);
            if (i == 11) check("fill_afull_12", 32'(bus.wr_afull), 1);
            $display("push %0d level=%0d", i, bus.level);
        end
        check("fill_level", 32'(bus.level),   16);
        check("fill_full",  32'(bus.wr_full), 1);
        step(1, 32'hDEAD, 0, 0);
        check("ovf_level", 32'(bus.level),  16);
        check("ovf_flag",  32'(bus.wr_ovf), 1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_data", bus.rd_data, 32'(i));
            $display("pop %0d data=0x%08h", i, bus.rd_data);
            step(0, 0, 1, 0);
        end
        check("drain_empty",  32'(bus.rd_empty),  1);
        check("drain_aempty", 32'(bus.rd_aempty), 1);
        check("drain_level",  32'(bus.level),     0);
        step(0, 0, 0, 1);
        check("flush_ovf_clr", 32'(bus.wr_ovf), 0);

        // 4. streaming across pointer wrap
        sent = 0; recv = 0; first_c = -1; last_c = -1; max_lvl = 0;
        for (int c = 0; c < 100 && recv < 40; c++) begin
            @(negedge clk);
            bus.wr_ena  = (sent < 40);
            bus.wr_data = 32'hC000_0000 + 32'(sent);
            bus.rd_ena  = !bus.rd_empty;
            bus.flush   = 1'b0;
            if (bus.rd_ena) begin
                check("stream_data", bus.rd_data, 32'hC000_0000 + 32'(recv));
                $display("stream rx %0d data=0x%08h cycle=%0d", recv, bus.rd_data, c);
                if (first_c < 0) first_c = c;
                last_c = c;
                recv++;
            end
            if (bus.wr_ena) sent++;
            @(posedge clk);
            #3;
            if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
        end
        step(0, 0, 0, 0);
        check("stream_count",  32'(recv), 40);
        check("stream_nogap",  32'(last_c - first_c), 39);
        check("stream_first",  32'(first_c), 2);
        check("stream_maxlvl", 32'(max_lvl <= 2), 1);
        check("stream_flags",  32'({bus.wr_ovf, bus.rd_udf}), 0);

        // 5. simultaneous push+pop at full and at empty
        for (int i = 0; i < DEPTH; i++) step(1, 32'h500 + 32'(i), 0, 0);
        step(1, 32'hBAD, 1, 0);
        check("sim_full_level", 32'(bus.level),  15);
        check("sim_full_ovf",   32'(bus.wr_ovf), 1);
        check("sim_full_head",  bus.rd_data, 32'h501);
        $display("simul at full: level=%0d ovf=%0d", bus.level, bus.wr_ovf);
        step(0, 0, 0, 1);
        step(1, 32'h77, 1, 0);
        check("sim_empty_level", 32'(bus.level),    1);
        check("sim_empty_udf",   32'(bus.rd_udf),   1);
        check("sim_empty_empty", 32'(bus.rd_empty), 1);
        step(0, 0, 0, 0);
        check("sim_empty_data", bus.rd_data, 32'h77);
        $display("simul at empty: level=%0d udf=%0d", bus.level, bus.rd_udf);

        // 6. flush at level 9 with a concurrent push
        step(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 32'h900 + 32'(i), 0, 0);
        check("fl_pre_level", 32'(bus.level), 9);
        step(1, 32'hFFFF, 0, 1);
        check("fl_level", 32'(bus.level),    0);
        check("fl_empty", 32'(bus.rd_empty), 1);
        check("fl_flags", 32'({bus.wr_ovf, bus.rd_udf}), 0);
        step(1, 32'h1234, 0, 0);
        check("fl_push_e0", 32'(bus.rd_empty), 1);
        step(0, 0, 0, 0);
        check("fl_push_e1", 32'(bus.rd_empty), 0);
        check("fl_data",    bus.rd_data, 32'h1234);
        step(0, 0, 1, 0);
        check("fl_final_empty", 32'(bus.rd_empty), 1);
        $display("flush: post-flush word=0x%08h", 32'h1234);

        step(0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
